nand_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one external bitwise NAND datapath unit (WIDTH-bit, purely combinational) among NREQ requesters. It arbitrates pending requests, drives the winner's operands to the shared unit and registers the result. It returns the result to the granted requester through a valid/ready handshake. It sits between the user-project pin decode logic and the shared NAND unit inside the top-level tile.

---
 rtl/nand_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_nand_rr_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nand_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational NAND unit among NREQ requesters.
// Grants one request per IDLE cycle, registers the result and returns it via valid/ready.
module nand_rr_scheduler #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [WIDTH-1:0]        nand_a,
   output logic [WIDTH-1:0]        nand_b,
   input  logic [WIDTH-1:0]        nand_y,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [WIDTH-1:0]        rsp_data,
   input  logic                    rsp_ready,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic [CNT_W-1:0]        op_count
);

   localparam int unsigned ID_W = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   win;
   logic              found;
   logic [WIDTH-1:0]  sel_a, sel_b;
   logic [NREQ-1:0]   grant_oh;

   // Rotating priority: lowest set bit at or above ptr, else lowest set bit overall.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i] && (ID_W'(i) >= ptr)) begin
            found = 1'b1;
            win   = ID_W'(i);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            win   = ID_W'(i);
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (ID_W'(i) == win) begin
            sel_a = req_a[i*WIDTH +: WIDTH];
            sel_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      grant_oh           = '0;
      grant_oh[grant_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state plus the same-cycle accept pulse.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (found) begin
               req_ready[win] = 1'b1;
               state_nxt      = ISSUE;
            end
         end
         ISSUE:   state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         nand_a    <= '0;
         nand_b    <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         grant_id  <= '0;
         op_count  <= '0;
         ptr       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  nand_a   <= sel_a;
                  nand_b   <= sel_b;
                  grant_id <= win;
                  ptr      <= (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
               end
            end
            ISSUE: begin
               rsp_data  <= nand_y;
               rsp_valid <= grant_oh;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= '0;
                  if (op_count != '1) op_count <= op_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_rr_scheduler.sv
// Directed bench for nand_rr_scheduler: vector table plus backpressure, reset and saturation sequences.
module tb_nand_rr_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a, req_b;
   logic [7:0]  nand_a, nand_b, nand_y;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_ready;
   logic        busy;
   logic [1:0]  grant_id;
   logic [15:0] op_count;

   logic [3:0]  req_ready2;
   logic [7:0]  nand_a2, nand_b2, nand_y2;
   logic [3:0]  rsp_valid2;
   logic [7:0]  rsp_data2;
   logic        busy2;
   logic [1:0]  grant_id2;
   logic [1:0]  op_count2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign nand_y  = ~(nand_a & nand_b);
   assign nand_y2 = ~(nand_a2 & nand_b2);

   nand_rr_scheduler #(.NREQ(4), .WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .nand_a(nand_a), .nand_b(nand_b), .nand_y(nand_y),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .busy(busy), .grant_id(grant_id), .op_count(op_count)
   );

   nand_rr_scheduler #(.NREQ(4), .WIDTH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
      .req_a(req_a), .req_b(req_b), .nand_a(nand_a2), .nand_b(nand_b2), .nand_y(nand_y2),
      .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_ready(rsp_ready),
      .busy(busy2), .grant_id(grant_id2), .op_count(op_count2)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] a;
      logic [31:0] b;
      logic        rr;
      logic [3:0]  e_rdy;
      logic [3:0]  e_rv;
      logic [7:0]  e_data;
      logic        e_busy;
      logic [1:0]  e_gid;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] a, logic [31:0] b, logic rr,
                               logic [3:0] erdy, logic [3:0] erv, logic [7:0] ed, logic eb,
                               logic [1:0] eg, logic [15:0] ec);
      vec_t t;
      t.rst = r; t.valid = v; t.a = a; t.b = b; t.rr = rr;
      t.e_rdy = erdy; t.e_rv = erv; t.e_data = ed; t.e_busy = eb; t.e_gid = eg; t.e_cnt = ec;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] SA = 32'h0000_00F0;
   localparam logic [31:0] SB = 32'h0000_00CC;
   localparam logic [31:0] FA = 32'hFFFF_FFFF;
   localparam logic [31:0] FB = 32'h0302_0100;

   initial begin
      logic [1:0] sat_exp[5];
      sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      tick();
      tick();
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_rsp_data",  32'(rsp_data), 0);
      chk("reset_nand_a",    32'(nand_a), 0);
      chk("reset_nand_b",    32'(nand_b), 0);
      chk("reset_busy",      32'(busy), 0);
      chk("reset_grant_id",  32'(grant_id), 0);
      chk("reset_op_count",  32'(op_count), 0);
      chk("reset_req_ready", 32'(req_ready), 0);
      rst = 1'b0;

      // single request
      vecs.push_back(mk(0, 4'h1, SA, SB, 1, 4'h1, 4'h0, 8'h00, 1, 0, 0));
      vecs.push_back(mk(0, 4'h0, SA, SB, 1, 4'h0, 4'h1, 8'h3F, 1, 0, 0));
      vecs.push_back(mk(0, 4'h0, SA, SB, 1, 4'h0, 4'h0, 8'h3F, 0, 0, 1));
      // full contention from reset
      vecs.push_back(mk(1, 4'h0, FA, FB, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h1, 4'h0, 8'h00, 1, 0, 0));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h0, 4'h1, 8'hFF, 1, 0, 0));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h0, 4'h0, 8'hFF, 0, 0, 1));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h2, 4'h0, 8'hFF, 1, 1, 1));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h0, 4'h2, 8'hFE, 1, 1, 1));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h0, 4'h0, 8'hFE, 0, 1, 2));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h4, 4'h0, 8'hFE, 1, 2, 2));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h0, 4'h4, 8'hFD, 1, 2, 2));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h0, 4'h0, 8'hFD, 0, 2, 3));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h8, 4'h0, 8'hFD, 1, 3, 3));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h0, 4'h8, 8'hFC, 1, 3, 3));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h0, 4'h0, 8'hFC, 0, 3, 4));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h1, 4'h0, 8'hFC, 1, 0, 4));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h0, 4'h1, 8'hFF, 1, 0, 4));
      vecs.push_back(mk(0, 4'hF, FA, FB, 1, 4'h0, 4'h0, 8'hFF, 0, 0, 5));
      // pointer wrap: grant 3, then 0 and 2 pending
      vecs.push_back(mk(1, 4'h0, FA, FB, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(0, 4'h8, FA, FB, 1, 4'h8, 4'h0, 8'h00, 1, 3, 0));
      vecs.push_back(mk(0, 4'h5, FA, FB, 1, 4'h0, 4'h8, 8'hFC, 1, 3, 0));
      vecs.push_back(mk(0, 4'h5, FA, FB, 1, 4'h0, 4'h0, 8'hFC, 0, 3, 1));
      vecs.push_back(mk(0, 4'h5, FA, FB, 1, 4'h1, 4'h0, 8'hFC, 1, 0, 1));
      vecs.push_back(mk(0, 4'h5, FA, FB, 1, 4'h0, 4'h1, 8'hFF, 1, 0, 1));
      vecs.push_back(mk(0, 4'h5, FA, FB, 1, 4'h0, 4'h0, 8'hFF, 0, 0, 2));
      vecs.push_back(mk(0, 4'h5, FA, FB, 1, 4'h4, 4'h0, 8'hFF, 1, 2, 2));
      vecs.push_back(mk(0, 4'h0, FA, FB, 1, 4'h0, 4'h4, 8'hFD, 1, 2, 2));
      vecs.push_back(mk(0, 4'h0, FA, FB, 1, 4'h0, 4'h0, 8'hFD, 0, 2, 3));

      foreach (vecs[i]) begin
         rst = vecs[i].rst; req_valid = vecs[i].valid; req_a = vecs[i].a;
         req_b = vecs[i].b; rsp_ready = vecs[i].rr;
         #1;
         chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
         tick();
         chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
         chk($sformatf("v%0d_rsp_data", i),  32'(rsp_data),  32'(vecs[i].e_data));
         chk($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].e_busy));
         chk($sformatf("v%0d_grant_id", i),  32'(grant_id),  32'(vecs[i].e_gid));
         chk($sformatf("v%0d_op_count", i),  32'(op_count),  32'(vecs[i].e_cnt));
      end

      // backpressure with a second requester waiting
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      tick();
      rst = 1'b0; req_valid = 4'b0011; req_a = 32'h0000_33AA; req_b = 32'h0000_0F55;
      #1;
      chk("bp_accept_rdy", 32'(req_ready), 32'h1);
      tick();
      chk("bp_issue_busy", 32'(busy), 1);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
         chk($sformatf("bp_hold%0d_rsp_data", i),  32'(rsp_data), 32'hFF);
         chk($sformatf("bp_hold%0d_req_ready", i), 32'(req_ready), 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_done_rsp_valid", 32'(rsp_valid), 0);
      chk("bp_done_op_count",  32'(op_count), 1);
      rsp_ready = 1'b0;
      #1;
      chk("bp_second_rdy", 32'(req_ready), 32'h2);

      // reset during RESP drops the transaction
      tick();
      chk("rm_grant_id", 32'(grant_id), 1);
      req_valid = '0;
      tick();
      chk("rm_resp_valid", 32'(rsp_valid), 32'h2);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rm_rsp_valid", 32'(rsp_valid), 0);
      chk("rm_busy",      32'(busy), 0);
      chk("rm_op_count",  32'(op_count), 0);
      chk("rm_grant_id0", 32'(grant_id), 0);
      req_valid = 4'b1001;
      #1;
      chk("rm_ptr_zero_rdy", 32'(req_ready), 32'h1);
      req_valid = '0;

      // saturating counter on the CNT_W=2 instance
      rst = 1'b1;
      tick();
      rst = 1'b0; rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         req_valid = 4'b0001;
         tick();
         req_valid = '0;
         tick();
         tick();
         chk($sformatf("sat%0d_op_count2", k), 32'(op_count2), 32'(sat_exp[k]));
         chk($sformatf("sat%0d_op_count", k),  32'(op_count), 32'(k + 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
